dmem_access_ctrl: RTL and testbench

- Initiator side of the DataMem port-A interface in KGP-RISC.
- Accepts load/store requests from the execute stage as base + signed offset (byte address), then checks alignment and range.
- Drives the single-port DataMem (we/addr/din), absorbs its fixed read latency, and returns load data or store completion over a valid/ready response channel.
- Sits between the EX stage and DataMem; the CPU stalls while req_ready is low.

---
 rtl/kgp_mem_pkg.sv | 17 +
 rtl/dmem_addr_chk.sv | 26 ++
 rtl/dmem_access_ctrl.sv | 145 ++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_mem_pkg.sv
// Shared DataMem constants and controller state encoding for KGP-RISC.
// Latency: none (declarations only).
// Backpressure: n/a.
package kgp_mem_pkg;

    localparam int ADDR_W   = 10;   // DataMem word-address width (1024 words)
    localparam int DATA_W   = 32;   // DataMem data width
    localparam int BYTE_OFF = 2;    // byte-offset bits within a 32-bit word

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/dmem_addr_chk.sv
// Effective-address adder with word-address slice and alignment/range flags.
// Latency: combinational.
// Backpressure: none; shared by the instruction-fetch side as well.
module dmem_addr_chk
    import kgp_mem_pkg::*;
#(
    parameter int ADDR_W = kgp_mem_pkg::ADDR_W
) (
    input  logic [31:0]       base,
    input  logic [31:0]       offset,
    output logic [ADDR_W-1:0] word_addr,
    output logic              misalign,
    output logic              out_of_range
);

    logic [31:0] ea;

    // Byte address is base + signed offset; 32-bit wrap-around is intentional.
    always_comb begin
        ea           = base + offset;
        word_addr    = ea[ADDR_W+BYTE_OFF-1:BYTE_OFF];
        misalign     = |ea[BYTE_OFF-1:0];
        out_of_range = |ea[31:ADDR_W+BYTE_OFF];
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Load/store initiator for DataMem port A: address check, issue, read-latency wait, response.
// Latency: error rsp at accept edge E0, store at E1, load at E(1+RD_LAT); all outputs registered.
// Backpressure: one request in flight; req_ready low until the response is taken with rsp_ready.
module dmem_access_ctrl
    import kgp_mem_pkg::*;
#(
    parameter int ADDR_W = kgp_mem_pkg::ADDR_W,
    parameter int DATA_W = kgp_mem_pkg::DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_base,
    input  logic [31:0]       req_offset,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_wea,
    output logic [ADDR_W-1:0] mem_addra,
    output logic [DATA_W-1:0] mem_dina,
    input  logic [DATA_W-1:0] mem_douta
);

    state_t            state, state_nxt;
    logic [1:0]        cnt, cnt_nxt;
    logic              req_ready_nxt, rsp_valid_nxt, rsp_err_nxt, mem_wea_nxt;
    logic [DATA_W-1:0] rsp_rdata_nxt, mem_dina_nxt;
    logic [ADDR_W-1:0] mem_addra_nxt;

    logic [ADDR_W-1:0] word_addr;
    logic              misalign, out_of_range;

    dmem_addr_chk #(
        .ADDR_W (ADDR_W)
    ) u_addr_chk (
        .base         (req_base),
        .offset       (req_offset),
        .word_addr    (word_addr),
        .misalign     (misalign),
        .out_of_range (out_of_range)
    );

    // State and every output register; reset also kills any in-flight write strobe.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_wea   <= 1'b0;
            mem_addra <= '0;
            mem_dina  <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            req_ready <= req_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
            mem_wea   <= mem_wea_nxt;
            mem_addra <= mem_addra_nxt;
            mem_dina  <= mem_dina_nxt;
        end
    end

    // Next-state and next-output values; registers hold unless a state changes them.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        req_ready_nxt = req_ready;
        rsp_valid_nxt = rsp_valid;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
        mem_wea_nxt   = 1'b0;
        mem_addra_nxt = mem_addra;
        mem_dina_nxt  = mem_dina;

        case (state)
            IDLE: begin
                req_ready_nxt = 1'b1;
                if (req_valid && req_ready) begin
                    req_ready_nxt = 1'b0;
                    if (misalign || out_of_range) begin
                        // Bad address: answer straight away, DataMem untouched.
                        state_nxt     = RESP;
                        rsp_valid_nxt = 1'b1;
                        rsp_err_nxt   = 1'b1;
                        rsp_rdata_nxt = '0;
                    end else begin
                        state_nxt     = ISSUE;
                        mem_addra_nxt = word_addr;
                        mem_wea_nxt   = req_we;
                        if (req_we) begin
                            mem_dina_nxt = req_wdata;
                        end
                    end
                end
            end

            ISSUE: begin
                // mem_wea still high here marks the operation as a store.
                if (mem_wea) begin
                    state_nxt     = RESP;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b0;
                    rsp_rdata_nxt = '0;
                end else begin
                    state_nxt = WAIT;
                    cnt_nxt   = 2'(RD_LAT - 1);
                end
            end

            WAIT: begin
                if (cnt == 2'd0) begin
                    state_nxt     = RESP;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b0;
                    rsp_rdata_nxt = mem_douta;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    state_nxt     = IDLE;
                    rsp_valid_nxt = 1'b0;
                    req_ready_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural DataMem (RD_LAT 1 and 2 instances).
// Latency: measured in edges from the accepting edge.
// Backpressure: rsp_ready held low on one load to check response stability.
module tb_dmem_access_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // RD_LAT=1 instance
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_base = '0, req_offset = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err, mem_wea;
    logic [31:0] rsp_rdata, mem_dina, mem_douta;
    logic [9:0]  mem_addra;

    // RD_LAT=2 instance (loads only)
    logic        req_valid2 = 1'b0, req_we2 = 1'b0, rsp_ready2 = 1'b0;
    logic [31:0] req_base2 = '0, req_offset2 = '0, req_wdata2 = '0;
    logic        req_ready2, rsp_valid2, rsp_err2, mem_wea2;
    logic [31:0] rsp_rdata2, mem_dina2, mem_douta2;
    logic [9:0]  mem_addra2;

    dmem_access_ctrl #(.ADDR_W(10), .DATA_W(32), .RD_LAT(1)) u_dut (
        .clka(clk), .rsta(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_wea(mem_wea), .mem_addra(mem_addra), .mem_dina(mem_dina), .mem_douta(mem_douta)
    );

    dmem_access_ctrl #(.ADDR_W(10), .DATA_W(32), .RD_LAT(2)) u_dut2 (
        .clka(clk), .rsta(rst),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2),
        .req_base(req_base2), .req_offset(req_offset2), .req_wdata(req_wdata2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2),
        .mem_wea(mem_wea2), .mem_addra(mem_addra2), .mem_dina(mem_dina2), .mem_douta(mem_douta2)
    );

    // Behavioural DataMem: synchronous write, registered read of RD_LAT stages.
    logic [31:0] mem [0:1023];
    logic [31:0] rd1, rd2a, rd2b;
    always @(posedge clk) begin
        if (mem_wea) mem[mem_addra] <= mem_dina;
        rd1  <= mem[mem_addra];
        rd2a <= mem[mem_addra2];
        rd2b <= rd2a;
    end
    assign mem_douta  = rd1;
    assign mem_douta2 = rd2b;

    int wea_cnt = 0, wea2_cnt = 0;
    always @(posedge clk) begin
        if (mem_wea)  wea_cnt++;
        if (mem_wea2) wea2_cnt++;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Present one request on the RD_LAT=1 port; lat counts edges after E0 until rsp_valid.
    task automatic do_req(input logic we, input logic [31:0] base, input logic [31:0] off,
                          input logic [31:0] wd, output int lat, output logic e0_wea);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_base = base; req_offset = off; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        e0_wea = mem_wea;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); lat++; @(negedge clk);
        end
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, ".rsp_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".rdy_back"}, 32'(req_ready), 32'd1);
    endtask

    int          lat, wea0;
    logic        e0w;
    logic [31:0] held;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;

        // Reset values
        #2;
        chk("rst.req_ready", 32'(req_ready), 32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_rdata", rsp_rdata, 32'd0);
        chk("rst.rsp_err",   32'(rsp_err), 32'd0);
        chk("rst.mem_wea",   32'(mem_wea), 32'd0);
        chk("rst.mem_addra", 32'(mem_addra), 32'd0);
        chk("rst.mem_dina",  mem_dina, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 chk("rel.req_ready_low", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("rel.req_ready_high", 32'(req_ready), 32'd1);

        // Store 5 to byte 8 (word 2)
        wea0 = wea_cnt;
        do_req(1'b1, 32'h0, 32'd8, 32'h5, lat, e0w);
        chk("st.lat",   32'(lat), 32'd1);
        chk("st.e0wea", 32'(e0w), 32'd1);
        chk("st.addra", 32'(mem_addra), 32'd2);
        chk("st.dina",  mem_dina, 32'h5);
        chk("st.err",   32'(rsp_err), 32'd0);
        chk("st.rdata", rsp_rdata, 32'd0);
        chk("st.wea_n", 32'(wea_cnt - wea0), 32'd1);
        finish_rsp("st");

        // Load it back via base 4 + 4
        do_req(1'b0, 32'h4, 32'd4, 32'h0, lat, e0w);
        chk("ld.lat",   32'(lat), 32'd2);
        chk("ld.e0wea", 32'(e0w), 32'd0);
        chk("ld.rdata", rsp_rdata, 32'h5);
        chk("ld.err",   32'(rsp_err), 32'd0);
        finish_rsp("ld");

        // Negative offset: 0x10 - 4 -> word 3
        do_req(1'b0, 32'h10, 32'hFFFF_FFFC, 32'h0, lat, e0w);
        chk("neg.addra", 32'(mem_addra), 32'd3);
        chk("neg.rdata", rsp_rdata, 32'h1000_0003);
        finish_rsp("neg");

        // Misaligned store: no DataMem write, immediate error
        wea0 = wea_cnt;
        do_req(1'b1, 32'h6, 32'h0, 32'hABCD, lat, e0w);
        chk("mis.lat",   32'(lat), 32'd0);
        chk("mis.err",   32'(rsp_err), 32'd1);
        chk("mis.rdata", rsp_rdata, 32'd0);
        chk("mis.addra", 32'(mem_addra), 32'd3);
        chk("mis.dina",  mem_dina, 32'h5);
        finish_rsp("mis");
        chk("mis.wea_n", 32'(wea_cnt - wea0), 32'd0);

        // Out of range: byte 0x1000
        do_req(1'b0, 32'h1000, 32'h0, 32'h0, lat, e0w);
        chk("oor.lat",   32'(lat), 32'd0);
        chk("oor.err",   32'(rsp_err), 32'd1);
        chk("oor.addra", 32'(mem_addra), 32'd3);
        finish_rsp("oor");

        // Highest legal word
        do_req(1'b0, 32'hFF8, 32'd4, 32'h0, lat, e0w);
        chk("top.err",   32'(rsp_err), 32'd0);
        chk("top.addra", 32'(mem_addra), 32'd1023);
        chk("top.rdata", rsp_rdata, 32'h1000_03FF);
        finish_rsp("top");

        // Wrap-around 0xFFFFFFFC + 4 -> 0 is legal
        do_req(1'b0, 32'hFFFF_FFFC, 32'd4, 32'h0, lat, e0w);
        chk("wrap.err",   32'(rsp_err), 32'd0);
        chk("wrap.addra", 32'(mem_addra), 32'd0);
        chk("wrap.rdata", rsp_rdata, 32'h1000_0000);
        finish_rsp("wrap");

        // Backpressure: response held for 5 cycles, new request ignored
        do_req(1'b0, 32'hC, 32'h0, 32'h0, lat, e0w);
        chk("bp.lat", 32'(lat), 32'd2);
        held = rsp_rdata;
        chk("bp.rdata", held, 32'h1000_0003);
        req_valid = 1'b1; req_we = 1'b1; req_base = 32'h40; req_offset = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            chk("bp.valid",     32'(rsp_valid), 32'd1);
            chk("bp.rdata_hold", rsp_rdata, held);
            chk("bp.req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        finish_rsp("bp");

        // RD_LAT=2 instance: response at E3
        @(negedge clk);
        req_valid2 = 1'b1; req_base2 = 32'hC;
        @(posedge clk); @(negedge clk);
        req_valid2 = 1'b0;
        lat = 0;
        while (!rsp_valid2 && lat < 20) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        chk("lat2.lat",   32'(lat), 32'd3);
        chk("lat2.rdata", rsp_rdata2, 32'h1000_0003);
        rsp_ready2 = 1'b1;
        @(posedge clk); @(negedge clk);
        rsp_ready2 = 1'b0;
        chk("lat2.rdy_back", 32'(req_ready2), 32'd1);

        // Reset during ISSUE of a store
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_base = 32'h20; req_offset = 32'h0; req_wdata = 32'h77;
        @(posedge clk);
        #1 chk("rmid.wea_issue", 32'(mem_wea), 32'd1);
        req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rmid.wea",       32'(mem_wea), 32'd0);
        chk("rmid.addra",     32'(mem_addra), 32'd0);
        chk("rmid.dina",      mem_dina, 32'd0);
        chk("rmid.req_ready", 32'(req_ready), 32'd0);
        chk("rmid.rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rmid.rel_low", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 chk("rmid.rel_high", 32'(req_ready), 32'd1);
        chk("rmid.rsp_after", 32'(rsp_valid), 32'd0);

        chk("tot.wea_n",  32'(wea_cnt), 32'd1);
        chk("tot.wea2_n", 32'(wea2_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
